// File: rtl/axi4l_timer_sched_if.sv
// AXI4-Lite bundle shared by the timer scheduler (master) and the machine-timer slave.
// aclk is carried for completeness; the scheduler runs from the same clock net.
interface axi4l_if (input logic aclk);
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    input  aclk,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4l_timer_sched.sv
// Multiplexes N_CH software deadlines onto one 64-bit mtimecmp: scans for the earliest
// armed deadline, programs it over AXI4-Lite, and pulses/disarms expired channels on irq.
module axi4l_timer_sched #(
  parameter int          N_CH       = 4,
  parameter logic [31:0] TIMER_BASE = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    irq,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_cancel,
  input  logic [$clog2(N_CH)-1:0] req_idx,
  input  logic [63:0]             req_deadline,
  output logic [N_CH-1:0]         expired,
  output logic                    busy,
  output logic                    err,
  axi4l_if.master                 axi
);
  localparam int IW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, SCAN, WR, WRESP} state_t;

  state_t          state_q, state_d;
  logic            fire_q, fire_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_CH-1:0] armed_q, armed_d;
  logic [63:0]     dl_q [N_CH];
  logic [63:0]     dl_d [N_CH];
  logic            min_vld_q, min_vld_d;
  logic [63:0]     min_dl_q, min_dl_d;
  logic            cur_valid_q, cur_valid_d;
  logic [63:0]     cur_dl_q, cur_dl_d;
  logic [N_CH-1:0] expired_q, expired_d;
  logic [1:0]      wr_cnt_q, wr_cnt_d;
  logic            aw_pend_q, aw_pend_d;
  logic            w_pend_q, w_pend_d;
  logic            err_q, err_d;

  logic [63:0]     vis_dl;
  logic            vis_fire, vis_min;
  logic            unused_ok;

  always_comb begin
    state_d     = state_q;
    fire_d      = fire_q;
    idx_d       = idx_q;
    armed_d     = armed_q;
    dl_d        = dl_q;
    min_vld_d   = min_vld_q;
    min_dl_d    = min_dl_q;
    cur_valid_d = cur_valid_q;
    cur_dl_d    = cur_dl_q;
    expired_d   = '0;
    wr_cnt_d    = wr_cnt_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    err_d       = err_q;

    // An entry that fires this visit is excluded from the minimum search.
    vis_dl    = dl_q[idx_q];
    vis_fire  = fire_q && armed_q[idx_q] && (vis_dl <= cur_dl_q);
    vis_min   = armed_q[idx_q] && !vis_fire && (!min_vld_q || (vis_dl < min_dl_q));
    req_ready = (state_q == IDLE) && !(irq && cur_valid_q);

    case (state_q)
      IDLE: begin
        if (irq && cur_valid_q) begin
          state_d   = SCAN;
          fire_d    = 1'b1;
          idx_d     = '0;
          min_vld_d = 1'b0;
        end else if (req_valid) begin
          armed_d[req_idx] = !req_cancel;
          dl_d[req_idx]    = req_deadline;
          state_d          = SCAN;
          fire_d           = 1'b0;
          idx_d            = '0;
          min_vld_d        = 1'b0;
        end
      end
      SCAN: begin
        if (vis_fire) begin
          armed_d[idx_q]   = 1'b0;
          expired_d[idx_q] = 1'b1;
        end
        if (vis_min) begin
          min_vld_d = 1'b1;
          min_dl_d  = vis_dl;
        end
        if (idx_q == IW'(N_CH - 1)) begin
          cur_valid_d = min_vld_d;
          cur_dl_d    = min_vld_d ? min_dl_d : '1;
          state_d     = WR;
          wr_cnt_d    = 2'd0;
          aw_pend_d   = 1'b1;
          w_pend_d    = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WR: begin
        if (aw_pend_q && axi.awready) aw_pend_d = 1'b0;
        if (w_pend_q && axi.wready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)  state_d   = WRESP;
      end
      WRESP: begin
        if (axi.bvalid) begin
          if (axi.bresp != 2'b00) err_d = 1'b1;
          if (wr_cnt_q == 2'd2) begin
            state_d = IDLE;
          end else begin
            wr_cnt_d  = wr_cnt_q + 2'd1;
            state_d   = WR;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fire_q      <= 1'b0;
      idx_q       <= '0;
      armed_q     <= '0;
      min_vld_q   <= 1'b0;
      cur_valid_q <= 1'b0;
      expired_q   <= '0;
      wr_cnt_q    <= 2'd0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fire_q      <= fire_d;
      idx_q       <= idx_d;
      armed_q     <= armed_d;
      min_vld_q   <= min_vld_d;
      cur_valid_q <= cur_valid_d;
      expired_q   <= expired_d;
      wr_cnt_q    <= wr_cnt_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    dl_q     <= dl_d;
    min_dl_q <= min_dl_d;
    cur_dl_q <= cur_dl_d;
  end

  // Low word parked at all-ones first so the half-updated compare can never fire early.
  always_comb begin
    case (wr_cnt_q)
      2'd0:    axi.wdata = 32'hFFFF_FFFF;
      2'd1:    axi.wdata = cur_dl_q[63:32];
      default: axi.wdata = cur_dl_q[31:0];
    endcase
  end

  assign axi.awaddr  = TIMER_BASE + ((wr_cnt_q == 2'd1) ? 32'h0000_000C : 32'h0000_0008);
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = aw_pend_q;
  assign axi.wstrb   = 4'hF;
  assign axi.wvalid  = w_pend_q;
  assign axi.bready  = (state_q == WRESP);
  assign axi.araddr  = '0;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = 1'b0;
  assign axi.rready  = 1'b0;

  assign expired = expired_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

  assign unused_ok = ^{axi.aclk, axi.arready, axi.rvalid, axi.rdata, axi.rresp};
endmodule
